// File: rtl/pri_enc_scan_disp.sv
// Priority encoder with a registered request path, a sequential binary-to-BCD converter
// and an active-low multiplexed seven-segment readout.
module pri_enc_scan_disp #(
  parameter int IN_W     = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024,
  localparam int YW      = $clog2(IN_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   x,
  input  logic              en,
  output logic [YW-1:0]     y,
  output logic              idc,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BW = 4 * DIGITS;
  localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(YW + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  function automatic logic [6:0] f_digit_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [IN_W-1:0]   r_x_q;
  logic              r_en_q;
  logic [YW-1:0]     r_y;
  logic              r_idc;
  logic [1:0]        r_state;
  logic              r_busy;
  logic              r_src_idc;
  logic [YW-1:0]     r_src_y;
  logic [YW-1:0]     r_sh;
  logic [BW-1:0]     r_bcd;
  logic [CW-1:0]     r_cnt;
  logic              r_s_idc;
  logic [YW-1:0]     r_s_y;
  logic [BW-1:0]     r_disp_bcd;
  logic [PW-1:0]     r_pre;
  logic [DW-1:0]     r_d;
  logic [6:0]        r_seg;
  logic [DIGITS-1:0] r_an;

  logic [YW-1:0]     w_y_enc;
  logic [BW-1:0]     w_bcd_adj;
  logic [BW-1:0]     w_bcd_step;
  logic              w_tc;
  logic [DW-1:0]     w_d_nx;
  logic              w_s_idc_nx;
  logic [BW-1:0]     w_disp_nx;
  logic [3:0]        w_nib;
  logic              w_upper_zero;
  logic [6:0]        w_seg_nx;

  // Highest set bit wins: later iterations overwrite lower indices.
  always_comb begin
    w_y_enc = '0;
    for (int i = 0; i < IN_W; i++) begin
      w_y_enc = r_x_q[i] ? YW'(i) : w_y_enc;
    end
  end

  // Two-stage request pipeline: capture inputs, then encode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_q  <= '0;
      r_en_q <= 1'b0;
      r_y    <= '0;
      r_idc  <= 1'b0;
    end else begin
      r_x_q  <= x;
      r_en_q <= en;
      r_idc  <= r_en_q & (|r_x_q);
      r_y    <= (r_en_q & (|r_x_q)) ? w_y_enc : '0;
    end
  end

  // Shift-add-3 step: correct nibbles >= 5 before doubling.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < DIGITS; k++) begin
      w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                       : r_bcd[4*k +: 4];
    end
    w_bcd_step = {w_bcd_adj[BW-2:0], r_sh[YW-1]};
  end

  // Converter FSM; the shown value only changes as a whole on the LOAD edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_src_idc  <= 1'b0;
      r_src_y    <= '0;
      r_sh       <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_s_idc    <= 1'b0;
      r_s_y      <= '0;
      r_disp_bcd <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ({r_idc, r_y} != {r_s_idc, r_s_y}) begin
            r_src_idc <= r_idc;
            r_src_y   <= r_y;
            r_sh      <= r_y;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd <= w_bcd_step;
          r_sh  <= r_sh << 1;
          if (r_cnt == CW'(YW - 1)) begin
            r_state <= ST_LOAD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_LOAD: begin
          r_disp_bcd <= r_bcd;
          r_s_idc    <= r_src_idc;
          r_s_y      <= r_src_y;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Glyphs are built from the display contents as they will be after this edge.
  always_comb begin
    w_tc         = (r_pre == PW'(SCAN_DIV - 1));
    w_d_nx       = w_tc ? ((r_d == DW'(DIGITS - 1)) ? '0 : (r_d + DW'(1))) : r_d;
    w_s_idc_nx   = (r_state == ST_LOAD) ? r_src_idc : r_s_idc;
    w_disp_nx    = (r_state == ST_LOAD) ? r_bcd : r_disp_bcd;
    w_nib        = w_disp_nx[4*w_d_nx +: 4];
    w_upper_zero = ((w_disp_nx >> (4 * w_d_nx)) == '0);
    if (!w_s_idc_nx) begin
      w_seg_nx = 7'h3F;
    end else if ((w_d_nx != '0) && w_upper_zero) begin
      w_seg_nx = 7'h7F;
    end else begin
      w_seg_nx = f_digit_seg(w_nib);
    end
  end

  // Digit scan prescaler and registered segment/anode drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_d   <= '0;
      r_seg <= 7'h3F;
      r_an  <= ~DIGITS'(1);
    end else begin
      r_pre <= w_tc ? '0 : (r_pre + PW'(1));
      r_d   <= w_d_nx;
      r_seg <= w_seg_nx;
      r_an  <= ~(DIGITS'(1) << w_d_nx);
    end
  end

  assign y    = r_y;
  assign idc  = r_idc;
  assign busy = r_busy;
  assign seg  = r_seg;
  assign an   = r_an;

endmodule

// File: tb/tb_pri_enc_scan_disp.sv
// Directed bench: an 8-bit and a 16-bit instance, both 3 digits with a fast scan.
module tb_pri_enc_scan_disp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  x8;
  logic        en8;
  logic [2:0]  y8;
  logic        idc8, busy8;
  logic [6:0]  seg8;
  logic [2:0]  an8;
  logic [15:0] x16;
  logic        en16;
  logic [3:0]  y16;
  logic        idc16, busy16;
  logic [6:0]  seg16;
  logic [2:0]  an16;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pri_enc_scan_disp #(.IN_W(8), .DIGITS(3), .SCAN_DIV(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .x(x8), .en(en8), .y(y8), .idc(idc8),
    .busy(busy8), .seg(seg8), .an(an8)
  );

  pri_enc_scan_disp #(.IN_W(16), .DIGITS(3), .SCAN_DIV(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .x(x16), .en(en16), .y(y16), .idc(idc16),
    .busy(busy16), .seg(seg16), .an(an16)
  );

  typedef struct {
    logic [7:0] x;
    logic       en;
    logic [2:0] y;
    logic       idc;
    int         busy_cyc;
    logic [6:0] s0, s1, s2;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scan a full display period and compare the glyph seen on each digit.
  task automatic check_digits(input bit sel, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input string tag);
    logic [6:0] got [3];
    logic [2:0] a;
    logic [6:0] s;
    logic [2:0] one;
    for (int j = 0; j < 3; j++) got[j] = 7'hxx;
    one = 3'b001;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      a = sel ? an16 : an8;
      s = sel ? seg16 : seg8;
      for (int j = 0; j < 3; j++) begin
        if (a == ~(one << j)) got[j] = s;
      end
    end
    chk({tag, " units"}, {25'd0, got[0]}, {25'd0, e0});
    chk({tag, " tens"}, {25'd0, got[1]}, {25'd0, e1});
    chk({tag, " hundreds"}, {25'd0, got[2]}, {25'd0, e2});
  endtask

  initial begin
    int cnt;
    logic [9:0] pat;
    logic [2:0] one;
    logic [15:0] xs16 [3];
    logic [3:0]  ys16 [3];
    logic [6:0]  u16  [3];
    one = 3'b001;

    vecs[0] = '{x: 8'h00, en: 1'b0, y: 3'd0, idc: 1'b0, busy_cyc: 0, s0: 7'h3F, s1: 7'h3F, s2: 7'h3F};
    vecs[1] = '{x: 8'h26, en: 1'b1, y: 3'd5, idc: 1'b1, busy_cyc: 4, s0: 7'h12, s1: 7'h7F, s2: 7'h7F};
    vecs[2] = '{x: 8'hFF, en: 1'b0, y: 3'd0, idc: 1'b0, busy_cyc: 4, s0: 7'h3F, s1: 7'h3F, s2: 7'h3F};
    vecs[3] = '{x: 8'h80, en: 1'b1, y: 3'd7, idc: 1'b1, busy_cyc: 4, s0: 7'h78, s1: 7'h7F, s2: 7'h7F};
    vecs[4] = '{x: 8'hFF, en: 1'b1, y: 3'd7, idc: 1'b1, busy_cyc: 0, s0: 7'h78, s1: 7'h7F, s2: 7'h7F};
    vecs[5] = '{x: 8'h01, en: 1'b1, y: 3'd0, idc: 1'b1, busy_cyc: 4, s0: 7'h40, s1: 7'h7F, s2: 7'h7F};
    vecs[6] = '{x: 8'h08, en: 1'b1, y: 3'd3, idc: 1'b1, busy_cyc: 4, s0: 7'h30, s1: 7'h7F, s2: 7'h7F};

    xs16[0] = 16'h1001; ys16[0] = 4'd12; u16[0] = 7'h24;
    xs16[1] = 16'h8000; ys16[1] = 4'd15; u16[1] = 7'h12;
    xs16[2] = 16'h0400; ys16[2] = 4'd10; u16[2] = 7'h40;

    x8 = 8'h00; en8 = 1'b0; x16 = 16'h0000; en16 = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset y", {29'd0, y8}, 32'd0);
    chk("reset idc", {31'd0, idc8}, 32'd0);
    chk("reset busy", {31'd0, busy8}, 32'd0);
    chk("reset an", {29'd0, an8}, {29'd0, 3'b110});
    chk("reset seg", {25'd0, seg8}, {25'd0, 7'h3F});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      chk("scan an", {29'd0, an8}, {29'd0, ~(one << (k / 4))});
      chk("scan seg", {25'd0, seg8}, {25'd0, 7'h3F});
      chk("idle busy", {31'd0, busy8}, 32'd0);
    end

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      x8 = vecs[i].x; en8 = vecs[i].en;
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d y", i), {29'd0, y8}, {29'd0, vecs[i].y});
      chk($sformatf("vec%0d idc", i), {31'd0, idc8}, {31'd0, vecs[i].idc});
      chk($sformatf("vec%0d busy early", i), {31'd0, busy8}, 32'd0);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (busy8) cnt++;
      end
      chk($sformatf("vec%0d busy cycles", i), cnt, vecs[i].busy_cyc);
      check_digits(1'b0, vecs[i].s0, vecs[i].s1, vecs[i].s2, $sformatf("vec%0d", i));
    end

    // Input changes while converting: a second pass starts right after LOAD.
    @(negedge clk);
    x8 = 8'h01; en8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("midchg busy start", {31'd0, busy8}, 32'd1);
    x8 = 8'h80;
    pat = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pat = {pat[8:0], busy8};
    end
    chk("midchg busy pattern", {22'd0, pat}, {22'd0, 10'b1110111100});
    chk("midchg y", {29'd0, y8}, 32'd7);
    check_digits(1'b0, 7'h78, 7'h7F, 7'h7F, "midchg");

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x16 = xs16[i]; en16 = 1'b1;
      repeat (2) @(negedge clk);
      chk($sformatf("w16_%0d y", i), {28'd0, y16}, {28'd0, ys16[i]});
      chk($sformatf("w16_%0d idc", i), {31'd0, idc16}, 32'd1);
      cnt = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (busy16) cnt++;
      end
      chk($sformatf("w16_%0d busy cycles", i), cnt, 5);
      check_digits(1'b1, u16[i], 7'h79, 7'h7F, $sformatf("w16_%0d", i));
    end

    // Reset in the middle of a conversion.
    @(negedge clk);
    x8 = 8'h26; en8 = 1'b1;
    repeat (4) @(negedge clk);
    chk("rstmid busy before", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    x8 = 8'h00; en8 = 1'b0; x16 = 16'h0000; en16 = 1'b0;
    #1;
    chk("rstmid busy", {31'd0, busy8}, 32'd0);
    chk("rstmid y", {29'd0, y8}, 32'd0);
    chk("rstmid idc", {31'd0, idc8}, 32'd0);
    chk("rstmid seg", {25'd0, seg8}, {25'd0, 7'h3F});
    chk("rstmid an", {29'd0, an8}, {29'd0, 3'b110});
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy8) cnt++;
    end
    chk("rstmid no conversion", cnt, 0);
    check_digits(1'b0, 7'h3F, 7'h3F, 7'h3F, "rstmid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
